pair_write_sequencer: RTL and testbench
=======================================

# pair_write_sequencer

Write-side companion to the paired-address read sweep: accepts a serial sample stream over a valid/ready handshake, packs consecutive samples into even/odd pairs, and writes each pair into a dual-port RAM in a single cycle. Port A takes the even address `{pair,0}` and port B takes the odd address `{pair,1}`. The pair index sweeps `START_PAIR` up to `END_PAIR-1`, so the buffer the read sweep consumes is filled in the same address order.

## Interface
Parameters:
- `ADDR_W`, 14, RAM word-address width; the pair index is `ADDR_W-1` bits.
- `DATA_W`, 16, sample width.
- `START_PAIR`, 1024, first pair index written (addresses 2048/2049).
- `END_PAIR`, 1536, exclusive end pair index; the last pair written is 1535 (addresses 3070/3071).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a fill; sampled only in IDLE or DONE.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  DATA_W  sample.
- `in_ready`  out  1  sample accepted on a cycle where `in_valid && in_ready`.
- `we_a`, `we_b`  out  1  write enables for RAM ports A and B; always asserted together.
- `addr_a`, `addr_b`  out  ADDR_W  `{pair,1'b0}` and `{pair,1'b1}`.
- `data_a`, `data_b`  out  DATA_W  even and odd sample of the pair.
- `busy`  out  1  fill in progress (states FIRST, SECOND, WRITE).
- `done`  out  1  level: the full range has been written; held until the next `start` or `reset`.

## Operation
States:
- **IDLE**: waiting for a fill request.
  - `start` → FIRST, with `pair` = `START_PAIR`.
- **FIRST**: `in_ready` = 1.
  - On accept, store `in_data` in the even register → SECOND.
- **SECOND**: `in_ready` = 1.
  - On accept, store `in_data` in the odd register → WRITE.
- **WRITE**: `in_ready` = 0; `we_a` = `we_b` = 1 for exactly one cycle.
  - Address and data outputs are stable during this cycle.
  - If `pair == END_PAIR-1` → DONE.
  - Otherwise `pair` increments by 1 → FIRST.
- **DONE**: `done` = 1, `in_ready` = 0.
  - `start` → FIRST, with `pair` reloaded to `START_PAIR` and `done` cleared.

Rules:
- `start` is ignored while `busy`.
- Addresses come from the registered pair index with a constant LSB.
- Pair arithmetic is unsigned and `ADDR_W-1` bits wide; the index never wraps because the range ends before overflow.
- `START_PAIR >= END_PAIR` is illegal; the bench checks this with an assertion.
- The even/odd registers hold their values outside of accepts, so `data_a`/`data_b` show the last pair written.
- `in_valid` low in FIRST or SECOND causes a stall with no timeout; the state and pair index are held.

## Timing
- Reset values:
  - state IDLE, `in_ready` 0, `we_a`/`we_b` 0;
  - `pair` = `START_PAIR`, so `addr_a` = 2048 and `addr_b` = 2049 with default parameters;
  - `data_a`/`data_b` 0, `busy` 0, `done` 0.
- `start` sampled in cycle N → `in_ready` = 1 in cycle N+1.
- Odd sample accepted in cycle M → write pulse in cycle M+1.
- Next even sample can be accepted in cycle M+2.
- Throughput is 2 samples per 3 cycles with continuous `in_valid`.
- Full default fill is 512 pairs, 1536 cycles after FIRST is entered.
- `done` rises the cycle after the final write pulse.
- Reset asserted mid-operation:
  - all outputs take their reset values immediately, with no write pulse;
  - a half-captured pair is discarded;
  - a new fill needs a fresh `start`.
- `start` in the same cycle as reset deassertion is ignored.

## Structure
- Shared package `pair_buf_pkg`:
  - state enum `pw_state_t` (IDLE, FIRST, SECOND, WRITE, DONE);
  - default constants `PAIR_START` = 1024, `PAIR_END` = 1536, `BUF_ADDR_W` = 14;
  - shared by this block and the read sweep.
- Single module with no sub-module.
- Optional bench-only dual-port RAM model `dp_ram_model`, two write ports.

## Test plan
1. Reset, then idle 5 cycles → `we_a`/`we_b` 0, `addr_a` = 2048, `addr_b` = 2049, `busy` 0, `done` 0.
2. `start`, then continuous stream 0,1,2,… → first write pulse writes `addr_a` = 2048 ← 0 and `addr_b` = 2049 ← 1. Last write is 3070 ← 1022 and 3071 ← 1023. `done` rises after 512 pulses, and the RAM model matches for all 1024 words.
3. Random `in_valid` gaps, including a stall between even and odd → same RAM contents as scenario 2, no extra or missing `we` pulses, exactly 1024 accepts.
4. Reset asserted after 3 of 4 samples of pair 1025 → no write to 2050 or 2051. Restart produces 2048 ← first sample of the new stream.
5. `start` pulsed during FIRST and during WRITE → ignored, pair index unchanged. `start` in DONE → `done` clears next cycle and 2048 is rewritten.
6. Parameters `START_PAIR` = 10, `END_PAIR` = 12 → exactly two write pulses, to 20/21 and 22/23, then `done`.

Source files
------------

// File: rtl/pair_buf_pkg.sv
// Shared definitions for the paired-address buffer: the write sequencer fills it
// and the read sweep consumes it.
package pair_buf_pkg;

  localparam int BUF_ADDR_W = 14;
  localparam int PAIR_START = 1024;
  localparam int PAIR_END   = 1536;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    SECOND = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } pw_state_t;

endpackage

// File: rtl/pair_write_sequencer.sv
// Packs a serial sample stream into even/odd pairs and writes each pair into a
// dual-port RAM in one cycle, sweeping pair index START_PAIR .. END_PAIR-1.
module pair_write_sequencer
  import pair_buf_pkg::*;
#(
  parameter int ADDR_W     = BUF_ADDR_W,
  parameter int DATA_W     = 16,
  parameter int START_PAIR = PAIR_START,
  parameter int END_PAIR   = PAIR_END
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we_a,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              busy,
  output logic              done,
  output pw_state_t         dbg_state
);

  localparam int PAIR_W = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] FIRST_PAIR = PAIR_W'(START_PAIR);
  localparam logic [PAIR_W-1:0] LAST_PAIR  = PAIR_W'(END_PAIR - 1);

  pw_state_t         r_state;
  logic [PAIR_W-1:0] r_pair;
  logic [DATA_W-1:0] r_even;
  logic [DATA_W-1:0] r_odd;
  logic              r_in_ready;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_armed;
  logic              w_accept;
  logic              w_start;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready.
  // in_ready is registered and depends only on state, never on in_valid.
  assign w_accept = in_valid && r_in_ready;

  // r_armed drops a start that coincides with the first edge after reset release.
  assign w_start  = start && r_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pair     <= FIRST_PAIR;
      r_even     <= '0;
      r_odd      <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_we    <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state    <= FIRST;
            r_pair     <= FIRST_PAIR;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        FIRST: begin
          if (w_accept) begin
            r_even  <= in_data;
            r_state <= SECOND;
          end
        end
        SECOND: begin
          if (w_accept) begin
            r_odd      <= in_data;
            r_state    <= WRITE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b1;
          end
        end
        WRITE: begin
          // The pair index advances only after its write cycle, keeping addresses stable.
          if (r_pair == LAST_PAIR) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_pair     <= r_pair + 1'b1;
            r_state    <= FIRST;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign we_a      = r_we;
  assign we_b      = r_we;
  assign addr_a    = {r_pair, 1'b0};
  assign addr_b    = {r_pair, 1'b1};
  assign data_a    = r_even;
  assign data_b    = r_odd;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pair_write_sequencer.sv
// Self-checking bench for pair_write_sequencer: directed vector table plus
// hand-written multi-cycle sequences, a RAM model and a write scoreboard.
module tb_pair_write_sequencer;
  import pair_buf_pkg::*;

  localparam int AW       = 14;
  localparam int DW       = 16;
  localparam int P2_START = 10;
  localparam int P2_END   = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // default-parameter instance
  logic          start = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, we_a, we_b, busy, done;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  pw_state_t     state1;

  // short-range instance
  logic          start2 = 1'b0, valid2 = 1'b0;
  logic [DW-1:0] data2 = '0;
  logic          ready2, we_a2, we_b2, busy2, done2;
  logic [AW-1:0] addr_a2, addr_b2;
  logic [DW-1:0] data_a2, data_b2;
  pw_state_t     state2;

  pair_write_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we_a(we_a), .we_b(we_b), .addr_a(addr_a), .addr_b(addr_b),
    .data_a(data_a), .data_b(data_b), .busy(busy), .done(done), .dbg_state(state1)
  );

  pair_write_sequencer #(.ADDR_W(AW), .DATA_W(DW), .START_PAIR(P2_START), .END_PAIR(P2_END)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(valid2), .in_data(data2),
    .in_ready(ready2), .we_a(we_a2), .we_b(we_b2), .addr_a(addr_a2), .addr_b(addr_b2),
    .data_a(data_a2), .data_b(data_b2), .busy(busy2), .done(done2), .dbg_state(state2)
  );

  initial begin
    assert (PAIR_START < PAIR_END) else $error("illegal default pair range");
    assert (P2_START < P2_END) else $error("illegal short pair range");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- RAM model and write monitors ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int we_count, busy_cycles, out_range, hits_2050, we_split, we2_count;

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cycles++;
      if (we_a !== we_b) we_split++;
      if (we_a) begin
        mem[addr_a] = data_a;
        mem[addr_b] = data_b;
        we_count++;
        if (addr_a < 14'd2048 || addr_b > 14'd3071) out_range++;
        if (addr_a == 14'd2050 || addr_b == 14'd2051) hits_2050++;
      end
    end
  end

  // scoreboard for the short-range instance: {addr, data} per written word
  logic [AW+DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset && we_a2) begin
      we2_count++;
      if (exp_q.size() < 2) begin
        check("dut2_extra_write", {addr_a2, data_a2}, '0);
      end else begin
        check("dut2_port_a", {addr_a2, data_a2}, exp_q.pop_front());
        check("dut2_port_b", {addr_b2, data_b2}, exp_q.pop_front());
      end
    end
  end

  task automatic clear_model();
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    we_count = 0; busy_cycles = 0; out_range = 0; hits_2050 = 0; we_split = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    start = 1'b0; in_valid = 1'b0; start2 = 1'b0; valid2 = 1'b0;
    reset = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; offers samples base, base+1, ... until n are accepted.
  task automatic feed(input int n, input int base, input int gap_pct, input int budget,
                      output int accepted);
    int cyc = 0;
    accepted = 0;
    while (accepted < n && cyc < budget) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = 16'(base + accepted);
      if (in_valid && in_ready) accepted++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    check(name, done, 1'b1);
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int a = 0; a < 1024; a++) if (mem[2048 + a] !== 16'(a)) bad++;
    check(name, bad, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          st;
    logic          vld;
    logic [DW-1:0] d;
    logic          rdy;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic          bsy;
    logic          dn;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  function automatic vec_t mk(input int st, input int vld, input int d, input int rdy,
                              input int we, input int a, input int da, input int db,
                              input int bsy, input int dn);
    vec_t v;
    v.st = 1'(st); v.vld = 1'(vld); v.d = 16'(d); v.rdy = 1'(rdy); v.we = 1'(we);
    v.a = 14'(a); v.da = 16'(da); v.db = 16'(db); v.bsy = 1'(bsy); v.dn = 1'(dn);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;

    //        st vld d      rdy we addr   da     db     bsy dn
    vecs[0]  = mk(0, 0, 'h000, 0, 0, 2048, 'h00, 'h00, 0, 0);
    vecs[1]  = mk(1, 0, 'h000, 0, 0, 2048, 'h00, 'h00, 0, 0);
    vecs[2]  = mk(0, 1, 'h00A, 1, 0, 2048, 'h00, 'h00, 1, 0);
    vecs[3]  = mk(0, 0, 'h0BB, 1, 0, 2048, 'h0A, 'h00, 1, 0);
    vecs[4]  = mk(0, 1, 'h00B, 1, 0, 2048, 'h0A, 'h00, 1, 0);
    vecs[5]  = mk(1, 1, 'h0FF, 0, 1, 2048, 'h0A, 'h0B, 1, 0);
    vecs[6]  = mk(1, 1, 'h00C, 1, 0, 2050, 'h0A, 'h0B, 1, 0);
    vecs[7]  = mk(0, 1, 'h00D, 1, 0, 2050, 'h0C, 'h0B, 1, 0);
    vecs[8]  = mk(0, 0, 'h000, 0, 1, 2050, 'h0C, 'h0D, 1, 0);
    vecs[9]  = mk(0, 0, 'h000, 1, 0, 2052, 'h0C, 'h0D, 1, 0);
    vecs[10] = mk(0, 1, 'h00E, 1, 0, 2052, 'h0C, 'h0D, 1, 0);
    vecs[11] = mk(0, 0, 'h000, 1, 0, 2052, 'h0E, 'h0D, 1, 0);

    // reset state held over 5 idle cycles
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_we_a", we_a, 1'b0);
      check("idle_we_b", we_b, 1'b0);
      check("idle_addr_a", addr_a, 14'd2048);
      check("idle_addr_b", addr_b, 14'd2049);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_ready", in_ready, 1'b0);
      check("idle_data_a", data_a, 16'h0);
    end

    // directed table: stall between even/odd, start in WRITE and FIRST ignored
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_ready", i), in_ready, vecs[i].rdy);
      check($sformatf("v%0d_we_a", i), we_a, vecs[i].we);
      check($sformatf("v%0d_we_b", i), we_b, vecs[i].we);
      check($sformatf("v%0d_addr_a", i), addr_a, vecs[i].a);
      check($sformatf("v%0d_addr_b", i), addr_b, vecs[i].a | 14'd1);
      check($sformatf("v%0d_data_a", i), data_a, vecs[i].da);
      check($sformatf("v%0d_data_b", i), data_b, vecs[i].db);
      check($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
      check($sformatf("v%0d_done", i), done, vecs[i].dn);
      start = vecs[i].st; in_valid = vecs[i].vld; in_data = vecs[i].d;
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;

    // full fill with a continuous stream 0,1,2,...
    do_reset();
    pulse_start();
    feed(1024, 0, 0, 5000, acc);
    check("fill_accepts", acc, 1024);
    wait_done("fill_done");
    #1;
    check("fill_pulses", we_count, 512);
    check("fill_busy_cycles", busy_cycles, 1536);
    check("fill_first_even", mem[2048], 16'd0);
    check("fill_first_odd", mem[2049], 16'd1);
    check("fill_last_even", mem[3070], 16'd1022);
    check("fill_last_odd", mem[3071], 16'd1023);
    check_ram("fill_ram");
    check("fill_out_range", out_range, 0);
    repeat (3) @(negedge clk);
    check("done_held", done, 1'b1);
    check("done_ready", in_ready, 1'b0);
    check("done_busy", busy, 1'b0);
    check("done_last_data_b", data_b, 16'd1023);

    // start while DONE restarts at the first pair
    pulse_start();
    check("restart_done_clear", done, 1'b0);
    check("restart_busy", busy, 1'b1);
    check("restart_ready", in_ready, 1'b1);
    check("restart_addr_a", addr_a, 14'd2048);
    feed(2, 'h5555, 0, 50, acc);
    repeat (2) @(negedge clk);
    #1;
    check("restart_even", mem[2048], 16'h5555);
    check("restart_odd", mem[2049], 16'h5556);
    check("restart_pulses", we_count, 513);

    // random valid gaps
    do_reset();
    pulse_start();
    feed(1024, 0, 40, 20000, acc);
    check("gap_accepts", acc, 1024);
    wait_done("gap_done");
    #1;
    check("gap_pulses", we_count, 512);
    check_ram("gap_ram");
    check("gap_out_range", out_range, 0);
    check("gap_we_split", we_split, 0);

    // reset with pair 1025 half captured
    do_reset();
    pulse_start();
    feed(3, 100, 0, 50, acc);
    reset = 1'b1;
    #1;
    check("mid_reset_we", we_a, 1'b0);
    check("mid_reset_ready", in_ready, 1'b0);
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_done", done, 1'b0);
    check("mid_reset_addr_a", addr_a, 14'd2048);
    check("mid_reset_data_a", data_a, 16'h0);
    check("mid_reset_data_b", data_b, 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_release_ignored", busy, 1'b0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("no_start_busy", busy, 1'b0);
    check("no_start_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    pulse_start();
    feed(2, 200, 0, 50, acc);
    repeat (3) @(negedge clk);
    #1;
    check("after_reset_even", mem[2048], 16'd200);
    check("after_reset_odd", mem[2049], 16'd201);
    check("no_write_2050", hits_2050, 0);

    // short range instance: two pairs 20/21 and 22/23
    check("p2_reset_addr_a", addr_a2, 14'd20);
    we2_count = 0;
    exp_q.push_back({14'd20, 16'h300});
    exp_q.push_back({14'd21, 16'h301});
    exp_q.push_back({14'd22, 16'h302});
    exp_q.push_back({14'd23, 16'h303});
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 50 && acc < 4; cyc++) begin
      valid2 = 1'b1;
      data2  = 16'(16'h300 + acc);
      if (ready2) acc++;
      @(negedge clk);
    end
    valid2 = 1'b0;
    for (int k = 0; k < 20 && !done2; k++) @(negedge clk);
    check("p2_done", done2, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("p2_pulses", we2_count, 2);
    check("p2_queue_empty", exp_q.size(), 0);
    check("p2_busy", busy2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
